// File: rtl/aes128_enc_round_ctrl.sv
// Iterative AES-128 encryption engine: one full round per clock over a single
// shared round datapath, with on-the-fly key expansion.
// Optional feature macro: AES_CTRL_KEY_WIPE_EN. When it is defined, the state,
// key and output registers are cleared on the output handshake, and out_block
// reads zero whenever out_valid is low.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif
`ifndef AES_WORD_SIZE
`define AES_WORD_SIZE 32
`endif

module aes128_enc_round_ctrl (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [`AES_BLOCK_SIZE-1:0] in_block,
    input  logic [`AES_BLOCK_SIZE-1:0] in_key,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`AES_BLOCK_SIZE-1:0] out_block,
    output logic                       busy
);
    localparam int BW = `AES_BLOCK_SIZE;
    localparam int WW = `AES_WORD_SIZE;

    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_t;

    state_t          state_reg, state_next;
    logic [3:0]      round_reg;
    logic [BW-1:0]   s_reg, k_reg, out_block_reg;
    logic [BW-1:0]   sub_bytes, shift_rows, mix_cols, round_out, k_next;
    logic [WW-1:0]   rot_word, sub_word, w0_next, w1_next, w2_next, w3_next;
    logic            last_round;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as inverse (x^254, so 0 maps to 0) followed by the affine map;
    // avoids a 256-entry table per byte lane.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign last_round = (round_reg == 4'd10);

    // Byte n of the state lives at [127-8n -: 8]; row = n%4, column = n/4.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            assign sub_bytes[BW-1-8*gi -: 8] = sbox(s_reg[BW-1-8*gi -: 8]);
            // Row r is rotated left by r columns.
            assign shift_rows[BW-1-8*gi -: 8] =
                sub_bytes[BW-1-8*(4*(((gi/4) + (gi%4)) % 4) + (gi%4)) -: 8];
        end
        for (gi = 0; gi < 4; gi++) begin : g_cols
            logic [7:0] a0, a1, a2, a3;
            assign a0 = shift_rows[BW-1-32*gi -: 8];
            assign a1 = shift_rows[BW-9-32*gi -: 8];
            assign a2 = shift_rows[BW-17-32*gi -: 8];
            assign a3 = shift_rows[BW-25-32*gi -: 8];
            assign mix_cols[BW-1-32*gi -: 8]  = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mix_cols[BW-9-32*gi -: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mix_cols[BW-17-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mix_cols[BW-25-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (gi = 0; gi < 4; gi++) begin : g_subword
            assign sub_word[WW-1-8*gi -: 8] = sbox(rot_word[WW-1-8*gi -: 8]);
        end
    endgenerate

    // Next round key from the current one and this round's Rcon.
    assign rot_word = {k_reg[WW-9:0], k_reg[WW-1 -: 8]};
    assign w0_next  = k_reg[BW-1 -: WW] ^ sub_word ^ {rcon(round_reg), 24'h000000};
    assign w1_next  = k_reg[BW-1-WW -: WW] ^ w0_next;
    assign w2_next  = k_reg[BW-1-2*WW -: WW] ^ w1_next;
    assign w3_next  = k_reg[WW-1:0] ^ w2_next;
    assign k_next   = {w0_next, w1_next, w2_next, w3_next};

    // The final round skips MixColumns.
    assign round_out = (last_round ? shift_rows : mix_cols) ^ k_next;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic and handshake/status outputs decoded from the state.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_ROUND;
            end
            ST_ROUND: begin
                busy = 1'b1;
                if (last_round) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Block state, round key, round counter and ciphertext holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg         <= '0;
            k_reg         <= '0;
            round_reg     <= 4'd0;
            out_block_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        s_reg     <= in_block ^ in_key;
                        k_reg     <= in_key;
                        round_reg <= 4'd1;
                    end
                end
                ST_ROUND: begin
                    s_reg <= round_out;
                    k_reg <= k_next;
                    if (last_round) begin
                        round_reg     <= 4'd0;
                        out_block_reg <= round_out;
                    end else begin
                        round_reg <= round_reg + 4'd1;
                    end
                end
                ST_DONE: begin
`ifdef AES_CTRL_KEY_WIPE_EN
                    if (out_ready) begin
                        s_reg         <= '0;
                        k_reg         <= '0;
                        out_block_reg <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef AES_CTRL_KEY_WIPE_EN
    assign out_block = out_valid ? out_block_reg : '0;
`else
    assign out_block = out_block_reg;
`endif

endmodule

// File: tb/tb_aes128_enc_round_ctrl.sv
// Self-checking bench for aes128_enc_round_ctrl: FIPS-197 vectors, latency,
// backpressure, back-to-back acceptance and mid-operation reset.
module tb_aes128_enc_round_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_block = '0;
    logic [127:0] in_key = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_block;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes128_enc_round_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_block(out_block), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every output handshake pops the oldest expected ciphertext.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %h expected none", out_block);
            end else begin
                $display("txn out_block=%h", out_block);
                check("scoreboard", out_block, exp_q.pop_front());
            end
        end
    end

    // Present one block for one cycle; caller sits just after a rising edge in IDLE.
    task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct);
        in_block = pt;
        in_key   = key;
        in_valid = 1'b1;
        exp_q.push_back(ct);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_block", out_block, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 C.1 with latency check and post-handshake out_block
        out_ready = 1'b1;
        send(C1_PT, C1_KEY, C1_CT);
        check("c1_busy", busy, 1);
        check("c1_in_ready_low", in_ready, 0);
        wait_valid(lat);
        check("c1_latency", lat, 10);
        @(posedge clk); #1;
        check("c1_after_hs_valid", out_valid, 0);
        check("c1_after_hs_ready", in_ready, 1);
`ifdef AES_CTRL_KEY_WIPE_EN
        check("c1_after_hs_block", out_block, 0);
`else
        check("c1_after_hs_block", out_block, C1_CT);
`endif

        // FIPS-197 B under 20 cycles of backpressure with ignored inputs
        out_ready = 1'b0;
        send(B_PT, B_KEY, B_CT);
        wait_valid(lat);
        check("b_latency", lat, 10);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_block = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || out_block !== B_CT)
                bad++;
        end
        check("bp_hold_violations", bad, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released_ready", in_ready, 1);
        check("bp_released_busy", busy, 0);

        // Back-to-back with in_valid held high
        exp_q.push_back(C1_CT);
        exp_q.push_back(B_CT);
        in_block = C1_PT;
        in_key   = C1_KEY;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_block = B_PT;
        in_key   = B_KEY;
        wait_valid(lat);
        check("b2b_first_latency", lat, 10);
        @(posedge clk); #1;
        check("b2b_gap_in_ready", in_ready, 1);
        check("b2b_gap_busy", busy, 0);
        @(posedge clk); #1;
        check("b2b_second_accept", busy, 1);
        in_valid = 1'b0;
        wait_valid(lat);
        check("b2b_second_latency", lat, 10);
        @(posedge clk); #1;

        // Reset at round 5, then a clean encryption
        send(C1_PT, C1_KEY, C1_CT);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_block", out_block, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(B_PT, B_KEY, B_CT);
        wait_valid(lat);
        check("post_rst_latency", lat, 10);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
